// File: rtl/calc_pkg.sv
// Shared key codes, FSM encoding and helpers for the calculator front end.
// Optional debounce build: KEY_ENTRY_DEBOUNCE_EN.
package calc_pkg;

  localparam logic [4:0] KEY_PLUS  = 5'd16;
  localparam logic [4:0] KEY_MINUS = 5'd17;
  localparam logic [4:0] KEY_BACKS = 5'd18;
  localparam logic [4:0] KEY_ENTER = 5'd19;
  localparam logic [4:0] KEY_UP    = 5'd20;
  localparam logic [4:0] KEY_DOWN  = 5'd21;
  localparam logic [4:0] KEY_NOP   = 5'd22;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_EMIT     = 2'd1;
  localparam logic [1:0] ST_WAIT_REL = 2'd2;

  function automatic logic is_digit(input logic [4:0] code);
    return code < 5'd10;
  endfunction

  function automatic logic is_cmd(input logic [4:0] code);
    return (code == KEY_PLUS) || (code == KEY_MINUS) ||
           (code == KEY_ENTER) || (code == KEY_UP) ||
           (code == KEY_DOWN);
  endfunction

  function automatic logic clears_entry(input logic [4:0] code);
    return (code == KEY_PLUS) || (code == KEY_MINUS) ||
           (code == KEY_ENTER);
  endfunction

endpackage

// File: rtl/key_entry_debounce.sv
// Stability counter producing a debounced press pulse and release level.
// Only instantiated when KEY_ENTRY_DEBOUNCE_EN is defined.
module key_debounce
  #(parameter int CYCLES = 1000)
  (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] i_key_val,
    input  logic       i_key_valid,
    output logic       o_press,
    output logic       o_released
  );

  localparam int CNTW = $clog2(CYCLES + 1);
  localparam logic [CNTW-1:0] C_LAST = CNTW'(CYCLES - 1);
  localparam logic [CNTW-1:0] C_SAT  = CNTW'(CYCLES);

  logic [4:0]      r_val;
  logic            r_valid;
  logic [CNTW-1:0] r_cnt;
  logic            w_chg;

  assign w_chg = (i_key_val != r_val) || (i_key_valid != r_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_val   <= i_key_val;
      r_valid <= i_key_valid;
      if (w_chg)
        r_cnt <= '0;
      else if (r_cnt != C_SAT)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // Press fires once as the count passes the threshold; saturation stops repeats
  assign o_press    = ~w_chg & i_key_valid & (r_cnt == C_LAST);
  assign o_released = ~w_chg & ~i_key_valid & (r_cnt >= C_LAST);

endmodule

// File: rtl/key_entry.sv
// Turns scanner key presses into BCD operand edits and command transactions.
// Optional debounce build: KEY_ENTRY_DEBOUNCE_EN.
module key_entry
  import calc_pkg::*;
  #(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000
  )
  (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [4:0]                   key_val,
    input  logic                         key_valid,
    output logic [4*DIGITS-1:0]          entry,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         overflow,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4:0]                   out_code,
    output logic [4*DIGITS-1:0]          out_operand,
    output logic [$clog2(DIGITS+1)-1:0]  out_digits
  );

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] C_MAX = CW'(DIGITS);

  logic         w_press;
  logic         w_released;
  logic [1:0]   r_state;
  logic [W-1:0] r_entry;
  logic [CW-1:0] r_count;
  logic         r_ovf;
  logic         r_valid;
  logic [4:0]   r_code;
  logic [W-1:0] r_op;
  logic [CW-1:0] r_odig;
  logic [W-1:0] w_shl;

`ifdef KEY_ENTRY_DEBOUNCE_EN
  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk         (clk),
    .rst         (rst),
    .i_key_val   (key_val),
    .i_key_valid (key_valid),
    .o_press     (w_press),
    .o_released  (w_released)
  );
`else
  logic r_key_prev;

  always_ff @(posedge clk) begin
    if (rst) r_key_prev <= 1'b0;
    else     r_key_prev <= key_valid;
  end

  assign w_press    = key_valid & ~r_key_prev;
  assign w_released = ~key_valid;
`endif

  assign w_shl = (r_entry << 4) | W'(key_val[3:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_entry <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_code  <= KEY_NOP;
      r_op    <= '0;
      r_odig  <= '0;
    end else begin
      r_ovf <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_press) begin
            r_state <= ST_WAIT_REL;
            if (is_digit(key_val)) begin
              if (r_count < C_MAX) begin
                r_entry <= w_shl;
                r_count <= r_count + 1'b1;
              end else begin
                r_ovf <= 1'b1;
              end
            end else if (key_val == KEY_BACKS) begin
              if (r_count != '0) begin
                r_entry <= r_entry >> 4;
                r_count <= r_count - 1'b1;
              end
            end else if (is_cmd(key_val)) begin
              r_code  <= key_val;
              r_op    <= r_entry;
              r_odig  <= r_count;
              r_valid <= 1'b1;
              r_state <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            if (clears_entry(r_code)) begin
              r_entry <= '0;
              r_count <= '0;
            end
            r_state <= w_released ? ST_IDLE : ST_WAIT_REL;
          end
        end
        ST_WAIT_REL: begin
          if (w_released) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign entry       = r_entry;
  assign digit_count = r_count;
  assign overflow    = r_ovf;
  assign out_valid   = r_valid;
  assign out_code    = r_code;
  assign out_operand = r_op;
  assign out_digits  = r_odig;

endmodule

// File: tb/tb_key_entry.sv
// Directed self-checking bench for key_entry (DIGITS=4).
// Debounce scenarios run when KEY_ENTRY_DEBOUNCE_EN is defined.
module tb_key_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  key_val;
  logic        key_valid;
  logic [15:0] entry;
  logic [2:0]  digit_count;
  logic        overflow;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_code;
  logic [15:0] out_operand;
  logic [2:0]  out_digits;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;
  int vld_cnt = 0;

`ifdef KEY_ENTRY_DEBOUNCE_EN
  localparam int HOLD = 12;
  localparam int GAP  = 12;
`else
  localparam int HOLD = 1;
  localparam int GAP  = 2;
`endif

  key_entry #(.DIGITS(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_val     (key_val),
    .key_valid   (key_valid),
    .entry       (entry),
    .digit_count (digit_count),
    .overflow    (overflow),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code),
    .out_operand (out_operand),
    .out_digits  (out_digits)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overflow)  ov_cnt++;
    if (out_valid) vld_cnt++;
  end

  task automatic press(input logic [4:0] code);
    @(negedge clk);
    key_val   = code;
    key_valid = 1'b1;
    repeat (HOLD) @(negedge clk);
    key_valid = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic chk_entry(input string nm, input logic [15:0] e,
                           input logic [2:0] c);
    checks++;
    if (entry !== e || digit_count !== c) begin
      errors++;
      $display("FAIL %s entry=%h count=%0d expected entry=%h count=%0d",
               nm, entry, digit_count, e, c);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; key_val = 5'd22; key_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (entry !== 16'h0 || digit_count !== 3'd0 || overflow !== 1'b0 ||
        out_valid !== 1'b0 || out_code !== 5'd22 ||
        out_operand !== 16'h0 || out_digits !== 3'd0) begin
      errors++;
      $display("FAIL reset entry=%h cnt=%0d ov=%b v=%b code=%0d op=%h od=%0d",
               entry, digit_count, overflow, out_valid, out_code,
               out_operand, out_digits);
    end
  endtask

  task automatic test_digits;
    vld_cnt = 0;
    press(5'd1); press(5'd2); press(5'd3);
    chk_entry("digits_123", 16'h0123, 3'd3);
    checks++;
    if (vld_cnt !== 0) begin
      errors++;
      $display("FAIL digits_no_valid got %0d expected 0", vld_cnt);
    end
  endtask

  task automatic test_overflow;
    ov_cnt = 0;
    press(5'd4);
    chk_entry("full_1234", 16'h1234, 3'd4);
    checks++;
    if (ov_cnt !== 0) begin
      errors++;
      $display("FAIL ovf_early got %0d expected 0", ov_cnt);
    end
    press(5'd5);
    chk_entry("ovf_entry", 16'h1234, 3'd4);
    checks++;
    if (ov_cnt !== 1) begin
      errors++;
      $display("FAIL ovf_pulse got %0d expected 1", ov_cnt);
    end
  endtask

  task automatic test_backspace;
    press(5'd18);
    chk_entry("backs1", 16'h0123, 3'd3);
    press(5'd18);
    chk_entry("backs2", 16'h0012, 3'd2);
    press(5'd18);
    chk_entry("backs3", 16'h0001, 3'd1);
    press(5'd18);
    chk_entry("backs4", 16'h0000, 3'd0);
    press(5'd18);
    chk_entry("backs_empty", 16'h0000, 3'd0);
  endtask

  task automatic test_plus_stall;
    press(5'd4); press(5'd2);
    chk_entry("pre_plus", 16'h0042, 3'd2);
    @(negedge clk);
    out_ready = 1'b0; vld_cnt = 0;
    key_val = 5'd16; key_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_code !== 5'd16 ||
        out_operand !== 16'h0042 || out_digits !== 3'd2) begin
      errors++;
      $display("FAIL plus_fields v=%b code=%0d op=%h od=%0d expected 1 16 0042 2",
               out_valid, out_code, out_operand, out_digits);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_code !== 5'd16 || out_operand !== 16'h0042) begin
      errors++;
      $display("FAIL plus_hold v=%b code=%0d op=%h expected 1 16 0042",
               out_valid, out_code, out_operand);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || vld_cnt !== 4) begin
      errors++;
      $display("FAIL plus_len v=%b cycles=%0d expected 0 4", out_valid, vld_cnt);
    end
    chk_entry("plus_clear", 16'h0000, 3'd0);
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_up;
    press(5'd7);
    out_ready = 1'b1; vld_cnt = 0;
    press(5'd20);
    checks++;
    if (vld_cnt !== 1 || out_code !== 5'd20 || out_operand !== 16'h0007) begin
      errors++;
      $display("FAIL up_txn cycles=%0d code=%0d op=%h expected 1 20 0007",
               vld_cnt, out_code, out_operand);
    end
    chk_entry("up_keep", 16'h0007, 3'd1);
  endtask

  task automatic test_held_and_emit;
    press(5'd19);
    chk_entry("enter_clear", 16'h0000, 3'd0);
    @(negedge clk);
    key_val = 5'd5; key_valid = 1'b1;
    repeat (50) @(negedge clk);
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_entry("held_once", 16'h0005, 3'd1);
    out_ready = 1'b0;
    key_val = 5'd17; key_valid = 1'b1;
    repeat (2) @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    key_val = 5'd9; key_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk_entry("emit_ignored", 16'h0005, 3'd1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_code !== 5'd17 || out_operand !== 16'h0005) begin
      errors++;
      $display("FAIL minus_txn v=%b code=%0d op=%h expected 0 17 0005",
               out_valid, out_code, out_operand);
    end
    chk_entry("after_minus", 16'h0000, 3'd0);
  endtask

  task automatic test_glitch;
    @(negedge clk);
    key_val = 5'd3; key_valid = 1'b1;
    repeat (5) @(negedge clk);
    key_valid = 1'b0;
    repeat (GAP) @(negedge clk);
    chk_entry("glitch_reject", 16'h0000, 3'd0);
    press(5'd3);
    chk_entry("debounced_press", 16'h0003, 3'd1);
  endtask

  initial begin
    test_reset;
`ifdef KEY_ENTRY_DEBOUNCE_EN
    test_glitch;
`else
    test_digits;
    test_overflow;
    test_backspace;
    test_plus_stall;
    test_up;
    test_held_and_emit;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
